// File: rtl/function_unit_if.sv
// rtl/function_unit_if.sv - issue/writeback bundle between decode, register file and function_unit
//
// Purpose: groups the issue signals (start, FS, DA_in, A, B) and the
// writeback/status signals (D, DA, RW, busy, Z, N, C, V) of function_unit.
// Ports (modport view):
//   master - issuer side: drives start/FS/DA_in/A/B, observes results
//   slave  - function_unit side: observes issue, drives results and status
interface function_unit_if;
  logic        start;
  logic [3:0]  FS;
  logic [3:0]  DA_in;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] D;
  logic [3:0]  DA;
  logic        RW;
  logic        busy;
  logic        Z;
  logic        N;
  logic        C;
  logic        V;

  modport master (
    output start, FS, DA_in, A, B,
    input  D, DA, RW, busy, Z, N, C, V
  );

  modport slave (
    input  start, FS, DA_in, A, B,
    output D, DA, RW, busy, Z, N, C, V
  );
endinterface

// File: rtl/function_unit.sv
// rtl/function_unit.sv - 16-bit execute stage: single-cycle ALU/shift ops plus optional iterative multiply
//
// Purpose: takes register-file operands A/B with a function select, computes
// the result and hands D/DA/RW back to the register file. Optional macro
// FU_MUL_EN adds a 16-cycle shift-add multiplier on FS=11; without it FS=11
// is treated as a reserved code and busy is tied low.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous, active-low
//   fu    - function_unit_if.slave: start/FS/DA_in/A/B in,
//           D/DA/RW/busy/Z/N/C/V out (all outputs registered or state-decoded)
module function_unit (
  input  logic           clk,
  input  logic           reset,
  function_unit_if.slave fu
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd2;
`ifdef FU_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [3:0] FS_MUL = 4'd11;
`endif

  localparam logic [3:0] FS_MOVA = 4'd0;
  localparam logic [3:0] FS_INC  = 4'd1;
  localparam logic [3:0] FS_ADD  = 4'd2;
  localparam logic [3:0] FS_SUB  = 4'd3;
  localparam logic [3:0] FS_DEC  = 4'd4;
  localparam logic [3:0] FS_AND  = 4'd5;
  localparam logic [3:0] FS_OR   = 4'd6;
  localparam logic [3:0] FS_XOR  = 4'd7;
  localparam logic [3:0] FS_NOT  = 4'd8;
  localparam logic [3:0] FS_SHL  = 4'd9;
  localparam logic [3:0] FS_SHR  = 4'd10;
  localparam logic [3:0] FS_MOVB = 4'd12;

  logic [1:0]  r_state;
  logic [15:0] r_d;
  logic [3:0]  r_da;
  logic        r_z;
  logic        r_n;
  logic        r_c;
  logic        r_v;

  logic [15:0] w_res;
  logic [16:0] w_sum;
  logic        w_c;
  logic        w_v;
  logic        w_single;

`ifdef FU_MUL_EN
  // Only the low 16 product bits are kept, so the multiplicand can shift
  // left inside a 16-bit register and simply lose its upper bits.
  logic [15:0] r_mcand;
  logic [15:0] r_mplier;
  logic [15:0] r_acc;
  logic [3:0]  r_count;
  logic [3:0]  r_mul_da;
  logic [15:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 16'h0000);
`endif

  // Single-cycle datapath; w_single marks codes that write back in one cycle.
  always_comb begin
    w_res    = '0;
    w_sum    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_single = 1'b1;
    case (fu.FS)
      FS_MOVA: w_res = fu.A;
      FS_INC: begin
        w_sum = {1'b0, fu.A} + 17'd1;
        w_res = w_sum[15:0];
        w_c   = w_sum[16];
        w_v   = ~fu.A[15] & w_sum[15];
      end
      FS_ADD: begin
        w_sum = {1'b0, fu.A} + {1'b0, fu.B};
        w_res = w_sum[15:0];
        w_c   = w_sum[16];
        w_v   = (fu.A[15] == fu.B[15]) && (w_sum[15] != fu.A[15]);
      end
      FS_SUB: begin
        // Carry out set means no borrow.
        w_sum = {1'b0, fu.A} + {1'b0, ~fu.B} + 17'd1;
        w_res = w_sum[15:0];
        w_c   = w_sum[16];
        w_v   = (fu.A[15] != fu.B[15]) && (w_sum[15] != fu.A[15]);
      end
      FS_DEC: begin
        // Adding 0xFFFF: overflow only when a negative A turns positive.
        w_sum = {1'b0, fu.A} + 17'h0FFFF;
        w_res = w_sum[15:0];
        w_c   = w_sum[16];
        w_v   = fu.A[15] & ~w_sum[15];
      end
      FS_AND:  w_res = fu.A & fu.B;
      FS_OR:   w_res = fu.A | fu.B;
      FS_XOR:  w_res = fu.A ^ fu.B;
      FS_NOT:  w_res = ~fu.A;
      FS_SHL: begin
        w_res = {fu.A[14:0], 1'b0};
        w_c   = fu.A[15];
      end
      FS_SHR: begin
        w_res = {1'b0, fu.A[15:1]};
        w_c   = fu.A[0];
      end
      FS_MOVB: w_res = fu.B;
      default: w_single = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_d      <= '0;
      r_da     <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
`ifdef FU_MUL_EN
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_mul_da <= '0;
`endif
    end else begin
      case (r_state)
`ifdef FU_MUL_EN
        S_MUL: begin
          // start is ignored here: a multiply in flight drops new issues.
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[15:1]};
          r_count  <= r_count + 4'd1;
          if (r_count == 4'd15) begin
            r_d     <= w_acc_next;
            r_da    <= r_mul_da;
            r_z     <= (w_acc_next == 16'h0000);
            r_n     <= w_acc_next[15];
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_state <= S_WB;
          end
        end
`endif
        default: begin
          if (fu.start && w_single) begin
            r_d     <= w_res;
            r_da    <= fu.DA_in;
            r_z     <= (w_res == 16'h0000);
            r_n     <= w_res[15];
            r_c     <= w_c;
            r_v     <= w_v;
            r_state <= S_WB;
          end
`ifdef FU_MUL_EN
          else if (fu.start && (fu.FS == FS_MUL)) begin
            // DA output keeps its old value until the product is written.
            r_mcand  <= fu.A;
            r_mplier <= fu.B;
            r_acc    <= '0;
            r_count  <= '0;
            r_mul_da <= fu.DA_in;
            r_state  <= S_MUL;
          end
`endif
          else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign fu.D  = r_d;
  assign fu.DA = r_da;
  assign fu.RW = (r_state == S_WB);
`ifdef FU_MUL_EN
  assign fu.busy = (r_state == S_MUL);
`else
  assign fu.busy = 1'b0;
`endif
  assign fu.Z = r_z;
  assign fu.N = r_n;
  assign fu.C = r_c;
  assign fu.V = r_v;

endmodule

// File: tb/tb_function_unit.sv
// tb/tb_function_unit.sv - directed scoreboard bench for function_unit
module tb_function_unit;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  da;
    logic [3:0]  f;   // {Z, N, C, V}
  } wb_t;

  typedef struct {
    logic [3:0]  fs;
    logic [3:0]  da;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic [3:0]  f;
  } op_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  function_unit_if fu ();

  function_unit dut (
    .clk   (clk),
    .reset (reset),
    .fu    (fu)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  wb_t sb_q[$];
  logic [15:0] last_d = 16'h0000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_wb(input logic [15:0] d, input logic [3:0] da, input logic [3:0] f);
    wb_t e;
    e.d = d;
    e.da = da;
    e.f = f;
    sb_q.push_back(e);
    last_d = d;
  endtask

  // Drive one issue cycle; returns 1 time unit after the sampling edge.
  task automatic drive(input logic [3:0] fs, input logic [3:0] da, input logic [15:0] a, input logic [15:0] b);
    fu.start = 1'b1;
    fu.FS = fs;
    fu.DA_in = da;
    fu.A = a;
    fu.B = b;
    @(posedge clk);
    #1;
    fu.start = 1'b0;
  endtask

  // Writeback monitor: every RW cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && fu.RW === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_rw", 16'(fu.RW), 16'h0000);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        chk("wb_d", fu.D, e.d);
        chk("wb_da", 16'(fu.DA), 16'(e.da));
        chk("wb_flags", 16'({fu.Z, fu.N, fu.C, fu.V}), 16'(e.f));
      end
    end
  end

  op_t ops[8];

  initial begin
    fu.start = 1'b0;
    fu.FS = 4'd0;
    fu.DA_in = 4'd0;
    fu.A = 16'h0000;
    fu.B = 16'h0000;

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d", fu.D, 16'h0000);
    chk("rst_da", 16'(fu.DA), 16'h0000);
    chk("rst_rw", 16'(fu.RW), 16'h0000);
    chk("rst_busy", 16'(fu.busy), 16'h0000);
    chk("rst_flags", 16'({fu.Z, fu.N, fu.C, fu.V}), 16'h0000);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // ADD 5+6 with a single-cycle RW pulse
    expect_wb(16'h000B, 4'd2, 4'b0000);
    drive(4'd2, 4'd2, 16'h0005, 16'h0006);
    chk("add_rw_on", 16'(fu.RW), 16'h0001);
    @(posedge clk);
    #1;
    chk("add_rw_off", 16'(fu.RW), 16'h0000);

    // SUB / ADD overflow / SHR issued back-to-back
    expect_wb(16'hFFFF, 4'd3, 4'b0100);
    drive(4'd3, 4'd3, 16'h0005, 16'h0006);
    expect_wb(16'h8000, 4'd4, 4'b0101);
    drive(4'd2, 4'd4, 16'h7FFF, 16'h0001);
    chk("b2b_rw", 16'(fu.RW), 16'h0001);
    expect_wb(16'h0000, 4'd5, 4'b1010);
    drive(4'd10, 4'd5, 16'h0001, 16'h0000);

    // Remaining ops from a table, also back-to-back
    ops[0] = '{4'd4,  4'd1,  16'h8000, 16'h0000, 16'h7FFF, 4'b0011};
    ops[1] = '{4'd9,  4'd9,  16'h8001, 16'h0000, 16'h0002, 4'b0010};
    ops[2] = '{4'd5,  4'd10, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100};
    ops[3] = '{4'd6,  4'd11, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000};
    ops[4] = '{4'd7,  4'd12, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000};
    ops[5] = '{4'd0,  4'd13, 16'h1234, 16'h5555, 16'h1234, 4'b0000};
    ops[6] = '{4'd12, 4'd14, 16'h1234, 16'hABCD, 16'hABCD, 4'b0100};
    ops[7] = '{4'd3,  4'd15, 16'h0009, 16'h0003, 16'h0006, 4'b0010};
    for (int i = 0; i < 8; i++) begin
      expect_wb(ops[i].d, ops[i].da, ops[i].f);
      drive(ops[i].fs, ops[i].da, ops[i].a, ops[i].b);
    end

    // INC wrap then NOT: RW continuous for two cycles, then reserved FS
    expect_wb(16'h0000, 4'd6, 4'b1010);
    drive(4'd1, 4'd6, 16'hFFFF, 16'h0000);
    chk("inc_rw", 16'(fu.RW), 16'h0001);
    expect_wb(16'hFF00, 4'd8, 4'b0100);
    drive(4'd8, 4'd8, 16'h00FF, 16'h0000);
    chk("not_rw", 16'(fu.RW), 16'h0001);
    drive(4'd14, 4'd3, 16'h1111, 16'h2222);
    chk("rsv_rw", 16'(fu.RW), 16'h0000);
    chk("rsv_d_hold", fu.D, 16'hFF00);
    chk("rsv_da_hold", 16'(fu.DA), 16'h0008);
    chk("rsv_flags_hold", 16'({fu.Z, fu.N, fu.C, fu.V}), 16'h0004);
    @(posedge clk);
    #1;
    chk("q_empty_alu", 16'(sb_q.size()), 16'h0000);

`ifdef FU_MUL_EN
    // MUL 0x12*0x34 = 0x03A8, with a dropped start while busy
    begin
      int n;
      expect_wb(16'h03A8, 4'd7, 4'b0000);
      drive(4'd11, 4'd7, 16'h0012, 16'h0034);
      chk("mul_da_hold", 16'(fu.DA), 16'h0008);
      n = 0;
      while (fu.busy === 1'b1 && n < 20) begin
        n++;
        if (n == 3) begin
          fu.start = 1'b1;
          fu.FS = 4'd2;
          fu.DA_in = 4'd9;
        end
        @(posedge clk);
        #1;
        fu.start = 1'b0;
      end
      chk("mul_busy_cycles", 16'(n), 16'd16);
      chk("mul_rw", 16'(fu.RW), 16'h0001);
      @(posedge clk);
      #1;
      chk("mul_rw_off", 16'(fu.RW), 16'h0000);
      repeat (3) @(posedge clk);
      #1;
      chk("q_empty_mul", 16'(sb_q.size()), 16'h0000);
    end

    // Reset on the 8th MUL cycle aborts without a writeback
    drive(4'd11, 4'd5, 16'h0003, 16'h0005);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_busy_pre", 16'(fu.busy), 16'h0001);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 16'(fu.busy), 16'h0000);
    chk("abort_rw", 16'(fu.RW), 16'h0000);
    chk("abort_d", fu.D, 16'h0000);
    chk("abort_da", 16'(fu.DA), 16'h0000);
    chk("abort_flags", 16'({fu.Z, fu.N, fu.C, fu.V}), 16'h0000);
    reset = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("abort_no_rw", 16'(fu.RW), 16'h0000);
    end
`else
    // Without the multiplier FS=11 behaves as reserved
    drive(4'd11, 4'd7, 16'h0012, 16'h0034);
    repeat (3) begin
      chk("nomul_busy", 16'(fu.busy), 16'h0000);
      chk("nomul_rw", 16'(fu.RW), 16'h0000);
      chk("nomul_d", fu.D, last_d);
      @(posedge clk);
      #1;
    end

    // Plain reset clears outputs
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_d", fu.D, 16'h0000);
    chk("rst2_flags", 16'({fu.Z, fu.N, fu.C, fu.V}), 16'h0000);
    reset = 1'b1;
`endif

    chk("q_empty_end", 16'(sb_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/function_unit.md
# function_unit

Execute stage fed directly by `register_file` read ports A/B; computes one of 13 operations and returns the result, destination address and write strobe to the register file's D/DA/RW inputs. Single-cycle ALU/shift ops, plus an optional 16-cycle iterative shift-add multiplier. Operates as a simple start/busy unit under the control/decode logic, which drives AA/BA/FS/DA_in.

## Interface
Parameters:
- none (datapath fixed at 16 bits, 16 registers)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- start  in  1  issue request; sampled on rising edge
- FS  in  4  function select, captured with start
- DA_in  in  4  destination register, captured with start
- A  in  16  operand A (register_file A output)
- B  in  16  operand B (register_file B output)
- D  out  16  registered result, to register_file D
- DA  out  4  registered destination, to register_file DA
- RW  out  1  write strobe, to register_file RW
- busy  out  1  high while a multiply is in progress
- Z, N, C, V  out  1 each  registered status flags of last written result

## Operation
- FS encoding (A, B 16-bit, results truncated to 16 bits): 0 MOVA=A; 1 INC=A+1; 2 ADD=A+B; 3 SUB=A+~B+1; 4 DEC=A+0xFFFF; 5 AND; 6 OR; 7 XOR; 8 NOT=~A; 9 SHL=A<<1; 10 SHR=A>>1 (logical); 11 MUL=low 16 bits of A*B (unsigned); 12 MOVB=B; 13–15 reserved.
- Flags: Z=(result==0); N=result[15]; C=carry-out of bit 15 for INC/ADD/SUB/DEC (SUB: C=1 means no borrow), shifted-out bit for SHL/SHR, else 0; V=signed overflow for INC/ADD/SUB/DEC, else 0. Flags update only when RW pulses.
- States: IDLE, MUL, WB.
  - IDLE/WB, start=1, single-cycle FS: capture DA_in, compute, load D/flags -> WB.
  - IDLE/WB, start=1, FS=MUL: load multiplicand=A, multiplier=B, acc=0, count=0 -> MUL.
  - IDLE/WB, start=1, reserved FS: no write, D/DA/flags hold -> IDLE.
  - IDLE/WB, start=0 -> IDLE.
  - MUL: each edge, if multiplier[0] acc+=multiplicand; multiplicand<<=1; multiplier>>=1; count++; on 16th MUL edge load D=acc (final), flags -> WB.
- RW=1 exactly in WB; busy=1 exactly in MUL.
- start while in MUL is ignored (dropped, not queued).
- reset=0: state IDLE, D=0, DA=0, RW=0, busy=0, Z=N=C=V=0, multiply datapath cleared. Reset during MUL aborts with no RW pulse.
- Read-after-write hazards are the issuer's responsibility; no forwarding.

## Timing
- Single-cycle op: start sampled at edge k -> RW=1, D/DA valid during cycle k..k+1; register file writes at edge k+1.
- MUL: start at edge k -> busy high after k through edge k+16; RW=1 during cycle after edge k+16 (17-cycle issue-to-write-edge).
- Back-to-back: new start accepted in WB, so consecutive single-cycle ops give continuous RW=1 with D/DA updating every cycle.
- A/B must be stable at the capturing edge; they are not used afterwards (MUL works on internal copies).

## Configuration
- FU_MUL_EN defined: FS=11 performs iterative multiply as above; busy may assert.
- FU_MUL_EN undefined: multiplier datapath and MUL state omitted; FS=11 treated as reserved (no RW, state IDLE); busy tied 0.

## Test plan
- Reset low 2 cycles then release; ADD A=0x0005 B=0x0006 DA_in=2 -> next cycle D=0x000B, DA=2, RW=1 for one cycle, Z=N=C=V=0.
- SUB A=0x0005 B=0x0006 -> D=0xFFFF, N=1, C=0; ADD A=0x7FFF B=0x0001 -> D=0x8000, V=1, N=1; SHR A=0x0001 -> D=0, Z=1, C=1.
- MUL A=0x0012 B=0x0034 DA_in=7 (FU_MUL_EN) -> busy 16 cycles, then D=0x03A8, DA=7, RW one cycle; extra start during busy produces no extra RW.
- Reset asserted on 8th MUL cycle -> busy=0, RW never pulses, all outputs 0 after edge.
- Back-to-back INC A=0xFFFF (D=0, Z=1, C=1) then NOT A=0x00FF (D=0xFF00, N=1) -> RW high two consecutive cycles; then FS=14 -> no RW, D holds 0xFF00.
- Build without FU_MUL_EN: FS=11 start -> busy stays 0, no RW, D unchanged.
